// File: rtl/pol_max_core_pkg.sv
// Shared definitions for the pooling max core and its CCU configuration logic.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package pol_max_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } pol_state_e;

  // Width of a neighbour-count field that must hold 0..nbr_max inclusive.
  function automatic int nbr_width(input int nbr_max);
    return $clog2(nbr_max + 1);
  endfunction

endpackage

// File: rtl/pol_max_core_if.sv
// Map, memory-interface and pooled-output channels of one pooling core.
// Latency: n/a (wiring only).
// Backpressure: each channel is valid/ready; master is the pooling core side.
interface pol_max_core_if #(
  parameter int POOL_COMP_CORE = 64,
  parameter int ACT_WIDTH      = 8,
  parameter int IDX_WIDTH      = 10,
  parameter int NBR_MAX        = 16
) ();

  // neighbour map from the global buffer
  logic                                GLBPOL_MapVld;
  logic [IDX_WIDTH*NBR_MAX-1:0]        GLBPOL_Map;
  logic                                POLGLB_MapRdy;
  // address requests and returned feature vectors
  logic                                POLMIF_AddrVld;
  logic [IDX_WIDTH-1:0]                POLMIF_Addr;
  logic                                MIFPOL_Rdy;
  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] MIFPOL_Ofm;
  logic                                MIFPOL_OfmVld;
  logic                                POLMIF_OfmRdy;
  // pooled vector back to the global buffer
  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] POLGLB_Ofm;
  logic                                POLGLB_OfmVld;
  logic                                GLBPOL_OfmRdy;

  modport master (
    input  GLBPOL_MapVld, GLBPOL_Map, MIFPOL_Rdy, MIFPOL_Ofm, MIFPOL_OfmVld, GLBPOL_OfmRdy,
    output POLGLB_MapRdy, POLMIF_AddrVld, POLMIF_Addr, POLMIF_OfmRdy, POLGLB_Ofm, POLGLB_OfmVld
  );

  modport slave (
    output GLBPOL_MapVld, GLBPOL_Map, MIFPOL_Rdy, MIFPOL_Ofm, MIFPOL_OfmVld, GLBPOL_OfmRdy,
    input  POLGLB_MapRdy, POLMIF_AddrVld, POLMIF_Addr, POLMIF_OfmRdy, POLGLB_Ofm, POLGLB_OfmVld
  );

endinterface

// File: rtl/pol_vec_max.sv
// Lane-wise unsigned maximum of two packed feature vectors.
// Latency: combinational.
// Backpressure: none.
module pol_vec_max #(
  parameter int POOL_COMP_CORE = 64,
  parameter int ACT_WIDTH      = 8
) (
  input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] a,
  input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] b,
  output logic [ACT_WIDTH*POOL_COMP_CORE-1:0] y
);

  // per-lane unsigned compare and select, no widening
  always_comb begin
    y = '0;
    for (int l = 0; l < POOL_COMP_CORE; l++) begin
      if (a[ACT_WIDTH*l +: ACT_WIDTH] >= b[ACT_WIDTH*l +: ACT_WIDTH])
        y[ACT_WIDTH*l +: ACT_WIDTH] = a[ACT_WIDTH*l +: ACT_WIDTH];
      else
        y[ACT_WIDTH*l +: ACT_WIDTH] = b[ACT_WIDTH*l +: ACT_WIDTH];
    end
  end

endmodule

// File: rtl/pol_max_core.sv
// Max-pooling core: per point, takes a neighbour map, fetches K vectors, emits their lane-wise max.
// Latency: K+3 cycles map handshake to next map ready with single-cycle memory and ready held high.
// Backpressure: address and pooled output hold until accepted; returns accepted only while rcv<K.
module pol_max_core
  import pol_max_core_pkg::*;
#(
  parameter int POOL_COMP_CORE = 64,
  parameter int ACT_WIDTH      = 8,
  parameter int IDX_WIDTH      = 10,
  parameter int NBR_MAX        = 16,
  parameter int NBR_WIDTH      = nbr_width(NBR_MAX)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 CCUPOL_Rst,
  input  logic                 CCUPOL_Start,
  input  logic [NBR_WIDTH-1:0] CCUPOL_K,
  input  logic [IDX_WIDTH-1:0] CCUPOL_NumPnt,
  output logic                 POLCCU_Busy,
  output logic                 POLCCU_Done,
  pol_max_core_if.master       bus
);

  localparam int VW = ACT_WIDTH * POOL_COMP_CORE;

  pol_state_e                   state, state_nxt;
  logic [NBR_WIDTH-1:0]         k_q, iss_q, rcv_q, iss_nxt, rcv_nxt;
  logic [IDX_WIDTH-1:0]         num_q, pnt_q;
  logic [IDX_WIDTH*NBR_MAX-1:0] map_q;
  logic [VW-1:0]                acc_q, acc_max;
  logic [IDX_WIDTH-1:0]         addr_sel;
  logic                         done_q, done_set;
  logic                         clr, map_hs, addr_hs, ret_hs, out_hs, last_pnt, ofm_rdy;

  assign clr      = !rst_n || CCUPOL_Rst;
  assign ofm_rdy  = ((state == ST_FETCH) || (state == ST_DRAIN)) && (rcv_q < k_q);
  assign map_hs   = (state == ST_LOAD) && bus.GLBPOL_MapVld;
  assign addr_hs  = (state == ST_FETCH) && bus.MIFPOL_Rdy;
  assign ret_hs   = ofm_rdy && bus.MIFPOL_OfmVld;
  assign out_hs   = (state == ST_OUT) && bus.GLBPOL_OfmRdy;
  assign iss_nxt  = iss_q + NBR_WIDTH'(addr_hs);
  assign rcv_nxt  = rcv_q + NBR_WIDTH'(ret_hs);
  assign last_pnt = ((pnt_q + IDX_WIDTH'(1)) == num_q);

  pol_vec_max #(
    .POOL_COMP_CORE(POOL_COMP_CORE),
    .ACT_WIDTH     (ACT_WIDTH)
  ) u_vec_max (
    .a(acc_q),
    .b(bus.MIFPOL_Ofm),
    .y(acc_max)
  );

  // select map entry iss as the current neighbour address
  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NBR_MAX; i++) begin
      if (iss_q == NBR_WIDTH'(i)) addr_sel = map_q[IDX_WIDTH*i +: IDX_WIDTH];
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next state, done request and output decode from registered state
  always_comb begin
    state_nxt          = state;
    done_set           = 1'b0;
    bus.POLGLB_MapRdy  = 1'b0;
    bus.POLMIF_AddrVld = 1'b0;
    bus.POLMIF_Addr    = '0;
    bus.POLMIF_OfmRdy  = ofm_rdy;
    bus.POLGLB_OfmVld  = 1'b0;
    bus.POLGLB_Ofm     = '0;
    POLCCU_Busy        = (state != ST_IDLE);
    POLCCU_Done        = done_q;
    case (state)
      ST_IDLE: begin
        if (CCUPOL_Start) begin
          if (CCUPOL_NumPnt == '0) done_set  = 1'b1;
          else                     state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bus.POLGLB_MapRdy = 1'b1;
        if (bus.GLBPOL_MapVld) state_nxt = (k_q == '0) ? ST_OUT : ST_FETCH;
      end
      ST_FETCH: begin
        bus.POLMIF_AddrVld = 1'b1;
        bus.POLMIF_Addr    = addr_sel;
        // last address and last return may complete in the same cycle
        if (iss_nxt == k_q) state_nxt = (rcv_nxt == k_q) ? ST_OUT : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (rcv_nxt == k_q) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        bus.POLGLB_OfmVld = 1'b1;
        bus.POLGLB_Ofm    = acc_q;
        if (bus.GLBPOL_OfmRdy) begin
          if (last_pnt) begin
            state_nxt = ST_IDLE;
            done_set  = 1'b1;
          end else begin
            state_nxt = ST_LOAD;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // configuration, counters, map word and max accumulator
  always_ff @(posedge clk) begin
    if (clr) begin
      k_q    <= '0;
      num_q  <= '0;
      pnt_q  <= '0;
      map_q  <= '0;
      iss_q  <= '0;
      rcv_q  <= '0;
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_set;
      if ((state == ST_IDLE) && CCUPOL_Start) begin
        k_q   <= CCUPOL_K;
        num_q <= CCUPOL_NumPnt;
        pnt_q <= '0;
      end
      if (map_hs) begin
        map_q <= bus.GLBPOL_Map;
        acc_q <= '0;
        iss_q <= '0;
        rcv_q <= '0;
      end else begin
        if (addr_hs) iss_q <= iss_nxt;
        if (ret_hs) begin
          rcv_q <= rcv_nxt;
          acc_q <= acc_max;
        end
      end
      if (out_hs) pnt_q <= pnt_q + IDX_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pol_max_core.sv
// Directed self-checking bench for pol_max_core.
// Latency: n/a.
// Backpressure: n/a.
module tb_pol_max_core;

  localparam int VW = 512;

  logic       clk = 1'b0;
  logic       rst_n, ccu_rst, ccu_start;
  logic [4:0] ccu_k;
  logic [9:0] ccu_num;
  logic       busy, done;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  pol_max_core_if #(.POOL_COMP_CORE(64), .ACT_WIDTH(8), .IDX_WIDTH(10), .NBR_MAX(16)) bus ();

  pol_max_core #(.POOL_COMP_CORE(64), .ACT_WIDTH(8), .IDX_WIDTH(10), .NBR_MAX(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .CCUPOL_Rst   (ccu_rst),
    .CCUPOL_Start (ccu_start),
    .CCUPOL_K     (ccu_k),
    .CCUPOL_NumPnt(ccu_num),
    .POLCCU_Busy  (busy),
    .POLCCU_Done  (done),
    .bus          (bus)
  );

  function automatic logic [VW-1:0] mkv(input logic [7:0] a0, input logic [7:0] a63, input logic [7:0] rest);
    logic [VW-1:0] v;
    for (int l = 0; l < 64; l++) v[8*l +: 8] = rest;
    v[7:0]      = a0;
    v[VW-1 -: 8] = a63;
    return v;
  endfunction

  function automatic logic [159:0] mkmap(input logic [9:0] e0, input logic [9:0] e1,
                                         input logic [9:0] e2, input logic [9:0] e3);
    logic [159:0] m;
    m = '0;
    m[9:0] = e0; m[19:10] = e1; m[29:20] = e2; m[39:30] = e3;
    return m;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start(input logic [4:0] k, input logic [9:0] n);
    ccu_start = 1'b1; ccu_k = k; ccu_num = n;
    tick();
    ccu_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({bus.POLGLB_MapRdy, bus.POLMIF_AddrVld, bus.POLMIF_OfmRdy, bus.POLGLB_OfmVld, busy, done} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 000000", {bus.POLGLB_MapRdy, bus.POLMIF_AddrVld, bus.POLMIF_OfmRdy, bus.POLGLB_OfmVld, busy, done});
    end
    n_cmp++;
    if (bus.POLMIF_Addr !== 10'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", bus.POLMIF_Addr); end
    n_cmp++;
    if (bus.POLGLB_Ofm !== '0) begin n_bad++; $display("FAIL reset_ofm: got %h want 0", bus.POLGLB_Ofm); end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.POLGLB_MapRdy !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: maprdy %b busy %b want 0 0", bus.POLGLB_MapRdy, busy);
    end
  endtask

  task automatic test_basic();
    logic [VW-1:0] rv [3];
    logic [9:0]    ea [3];
    rv[0] = mkv(8'd10, 8'd3, 8'd1); rv[1] = mkv(8'd200, 8'd250, 8'd2); rv[2] = mkv(8'd7, 8'd0, 8'd9);
    ea[0] = 10'd5; ea[1] = 10'd9; ea[2] = 10'd2;
    bus.MIFPOL_Rdy = 1'b1;
    start(5'd3, 10'd1);
    n_cmp++;
    if (bus.POLGLB_MapRdy !== 1'b1) begin n_bad++; $display("FAIL basic_maprdy: got %b want 1", bus.POLGLB_MapRdy); end
    bus.GLBPOL_MapVld = 1'b1; bus.GLBPOL_Map = mkmap(10'd5, 10'd9, 10'd2, 10'd0);
    tick();
    bus.GLBPOL_MapVld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.POLMIF_AddrVld !== 1'b1 || bus.POLMIF_Addr !== ea[i]) begin
        n_bad++; $display("FAIL basic_addr%0d: got vld %b addr %0d want 1 %0d", i, bus.POLMIF_AddrVld, bus.POLMIF_Addr, ea[i]);
      end
      bus.MIFPOL_OfmVld = (i > 0);
      if (i > 0) bus.MIFPOL_Ofm = rv[i-1];
      tick();
    end
    n_cmp++;
    if (bus.POLMIF_AddrVld !== 1'b0 || bus.POLGLB_OfmVld !== 1'b0) begin
      n_bad++; $display("FAIL basic_drain: got addrvld %b ofmvld %b want 0 0", bus.POLMIF_AddrVld, bus.POLGLB_OfmVld);
    end
    bus.MIFPOL_OfmVld = 1'b1; bus.MIFPOL_Ofm = rv[2];
    tick();
    bus.MIFPOL_OfmVld = 1'b0;
    n_cmp++;
    if (bus.POLGLB_OfmVld !== 1'b1 || bus.POLGLB_Ofm !== mkv(8'd200, 8'd250, 8'd9)) begin
      n_bad++; $display("FAIL basic_out: got vld %b ofm %h want 1 %h", bus.POLGLB_OfmVld, bus.POLGLB_Ofm, mkv(8'd200, 8'd250, 8'd9));
    end
    bus.GLBPOL_OfmRdy = 1'b1;
    tick();
    bus.GLBPOL_OfmRdy = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_done: got done %b busy %b want 1 0", done, busy); end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_rdy_toggle();
    logic [VW-1:0] rv [4];
    logic [9:0]    ea [7];
    logic          rdy [7];
    logic          vld [7];
    int            ri;
    rv[0] = mkv(8'd1, 8'd2, 8'd3);  rv[1] = mkv(8'd40, 8'd5, 8'd6);
    rv[2] = mkv(8'd7, 8'd8, 8'd90); rv[3] = mkv(8'd4, 8'd99, 8'd0);
    ea  = '{10'd100, 10'd101, 10'd101, 10'd102, 10'd102, 10'd103, 10'd103};
    rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vld = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ri = 0;
    start(5'd4, 10'd1);
    bus.GLBPOL_MapVld = 1'b1; bus.GLBPOL_Map = mkmap(10'd100, 10'd101, 10'd102, 10'd103);
    tick();
    bus.GLBPOL_MapVld = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (bus.POLMIF_AddrVld !== 1'b1 || bus.POLMIF_Addr !== ea[i] || bus.POLGLB_OfmVld !== 1'b0) begin
        n_bad++;
        $display("FAIL toggle_cyc%0d: got addrvld %b addr %0d ofmvld %b want 1 %0d 0", i, bus.POLMIF_AddrVld, bus.POLMIF_Addr, bus.POLGLB_OfmVld, ea[i]);
      end
      if (i == 6) begin
        n_cmp++;
        if (bus.POLMIF_OfmRdy !== 1'b0) begin n_bad++; $display("FAIL toggle_ofmrdy_full: got %b want 0", bus.POLMIF_OfmRdy); end
      end
      bus.MIFPOL_Rdy = rdy[i];
      bus.MIFPOL_OfmVld = vld[i];
      if (vld[i]) begin bus.MIFPOL_Ofm = rv[ri]; ri++; end
      tick();
    end
    bus.MIFPOL_OfmVld = 1'b0; bus.MIFPOL_Rdy = 1'b1;
    n_cmp++;
    if (bus.POLGLB_OfmVld !== 1'b1 || bus.POLGLB_Ofm !== mkv(8'd40, 8'd99, 8'd90)) begin
      n_bad++; $display("FAIL toggle_out: got vld %b ofm %h want 1 %h", bus.POLGLB_OfmVld, bus.POLGLB_Ofm, mkv(8'd40, 8'd99, 8'd90));
    end
    bus.GLBPOL_OfmRdy = 1'b1;
    tick();
    bus.GLBPOL_OfmRdy = 1'b0;
    tick();
  endtask

  task automatic test_out_hold();
    bus.MIFPOL_Rdy = 1'b1;
    start(5'd2, 10'd2);
    bus.GLBPOL_MapVld = 1'b1; bus.GLBPOL_Map = mkmap(10'd7, 10'd8, 10'd0, 10'd0);
    tick();
    bus.GLBPOL_MapVld = 1'b0;
    bus.MIFPOL_OfmVld = 1'b0;
    tick();
    bus.MIFPOL_OfmVld = 1'b1; bus.MIFPOL_Ofm = mkv(8'd11, 8'd0, 8'd0);
    tick();
    bus.MIFPOL_Ofm = mkv(8'd22, 8'd0, 8'd5);
    tick();
    bus.MIFPOL_OfmVld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.POLGLB_OfmVld !== 1'b1 || bus.POLGLB_Ofm !== mkv(8'd22, 8'd0, 8'd5) || bus.POLGLB_MapRdy !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_cyc%0d: got vld %b maprdy %b ofm %h want 1 0 %h", i, bus.POLGLB_OfmVld, bus.POLGLB_MapRdy, bus.POLGLB_Ofm, mkv(8'd22, 8'd0, 8'd5));
      end
      tick();
    end
    bus.GLBPOL_OfmRdy = 1'b1;
    tick();
    bus.GLBPOL_OfmRdy = 1'b0;
    n_cmp++;
    if (bus.POLGLB_MapRdy !== 1'b1 || bus.POLGLB_OfmVld !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL hold_next_load: got maprdy %b ofmvld %b done %b want 1 0 0", bus.POLGLB_MapRdy, bus.POLGLB_OfmVld, done);
    end
    // second point: returns arrive as early as the core will take them
    bus.GLBPOL_MapVld = 1'b1; bus.GLBPOL_Map = mkmap(10'd3, 10'd4, 10'd0, 10'd0);
    tick();
    bus.GLBPOL_MapVld = 1'b0;
    bus.MIFPOL_OfmVld = 1'b1; bus.MIFPOL_Ofm = mkv(8'd1, 8'd2, 8'd3);
    tick(); tick();
    bus.MIFPOL_OfmVld = 1'b0;
    n_cmp++;
    if (bus.POLGLB_OfmVld !== 1'b1 || bus.POLGLB_Ofm !== mkv(8'd1, 8'd2, 8'd3)) begin
      n_bad++; $display("FAIL hold_pt2_out: got vld %b ofm %h want 1 %h", bus.POLGLB_OfmVld, bus.POLGLB_Ofm, mkv(8'd1, 8'd2, 8'd3));
    end
    bus.GLBPOL_OfmRdy = 1'b1;
    tick();
    bus.GLBPOL_OfmRdy = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL hold_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_k_zero();
    start(5'd0, 10'd2);
    bus.GLBPOL_MapVld = 1'b1; bus.GLBPOL_Map = mkmap(10'd1, 10'd2, 10'd3, 10'd4);
    tick();
    n_cmp++;
    if (bus.POLMIF_AddrVld !== 1'b0 || bus.POLGLB_OfmVld !== 1'b1 || bus.POLGLB_Ofm !== '0) begin
      n_bad++; $display("FAIL k0_out1: got addrvld %b vld %b ofm %h want 0 1 0", bus.POLMIF_AddrVld, bus.POLGLB_OfmVld, bus.POLGLB_Ofm);
    end
    bus.GLBPOL_OfmRdy = 1'b1;
    tick();
    bus.GLBPOL_OfmRdy = 1'b0;
    n_cmp++;
    if (bus.POLGLB_MapRdy !== 1'b1 || done !== 1'b0 || bus.POLMIF_AddrVld !== 1'b0) begin
      n_bad++; $display("FAIL k0_load2: got maprdy %b done %b addrvld %b want 1 0 0", bus.POLGLB_MapRdy, done, bus.POLMIF_AddrVld);
    end
    tick();
    bus.GLBPOL_MapVld = 1'b0;
    n_cmp++;
    if (bus.POLGLB_OfmVld !== 1'b1 || bus.POLGLB_Ofm !== '0) begin
      n_bad++; $display("FAIL k0_out2: got vld %b ofm %h want 1 0", bus.POLGLB_OfmVld, bus.POLGLB_Ofm);
    end
    bus.GLBPOL_OfmRdy = 1'b1;
    tick();
    bus.GLBPOL_OfmRdy = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL k0_done: got done %b busy %b want 1 0", done, busy); end
    tick();
  endtask

  task automatic test_zero_points();
    start(5'd2, 10'd0);
    n_cmp++;
    if (done !== 1'b1 || bus.POLGLB_MapRdy !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL np0_done: got done %b maprdy %b busy %b want 1 0 0", done, bus.POLGLB_MapRdy, busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || bus.POLGLB_MapRdy !== 1'b0) begin
      n_bad++; $display("FAIL np0_after: got done %b maprdy %b want 0 0", done, bus.POLGLB_MapRdy);
    end
  endtask

  task automatic test_soft_rst();
    bus.MIFPOL_Rdy = 1'b1;
    start(5'd3, 10'd1);
    bus.GLBPOL_MapVld = 1'b1; bus.GLBPOL_Map = mkmap(10'd1, 10'd2, 10'd3, 10'd0);
    tick();
    bus.GLBPOL_MapVld = 1'b0;
    tick();
    bus.MIFPOL_OfmVld = 1'b1; bus.MIFPOL_Ofm = mkv(8'd255, 8'd255, 8'd255);
    tick();
    bus.MIFPOL_OfmVld = 1'b0;
    tick();
    n_cmp++;
    if (bus.POLMIF_AddrVld !== 1'b0 || bus.POLMIF_OfmRdy !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL srst_drain: got addrvld %b ofmrdy %b busy %b want 0 1 1", bus.POLMIF_AddrVld, bus.POLMIF_OfmRdy, busy);
    end
    ccu_rst = 1'b1;
    tick();
    ccu_rst = 1'b0;
    n_cmp++;
    if ({bus.POLGLB_MapRdy, bus.POLMIF_AddrVld, bus.POLMIF_OfmRdy, bus.POLGLB_OfmVld, busy, done} !== 6'b0
        || bus.POLMIF_Addr !== 10'd0 || bus.POLGLB_Ofm !== '0) begin
      n_bad++;
      $display("FAIL srst_outputs: got ctl %b addr %0d want 000000 0", {bus.POLGLB_MapRdy, bus.POLMIF_AddrVld, bus.POLMIF_OfmRdy, bus.POLGLB_OfmVld, busy, done}, bus.POLMIF_Addr);
    end
    start(5'd1, 10'd1);
    bus.GLBPOL_MapVld = 1'b1; bus.GLBPOL_Map = mkmap(10'd42, 10'd0, 10'd0, 10'd0);
    tick();
    bus.GLBPOL_MapVld = 1'b0;
    n_cmp++;
    if (bus.POLMIF_AddrVld !== 1'b1 || bus.POLMIF_Addr !== 10'd42) begin
      n_bad++; $display("FAIL srst_k1_addr: got vld %b addr %0d want 1 42", bus.POLMIF_AddrVld, bus.POLMIF_Addr);
    end
    tick();
    bus.MIFPOL_OfmVld = 1'b1; bus.MIFPOL_Ofm = mkv(8'd77, 8'd1, 8'd2);
    tick();
    bus.MIFPOL_OfmVld = 1'b0;
    n_cmp++;
    if (bus.POLGLB_OfmVld !== 1'b1 || bus.POLGLB_Ofm !== mkv(8'd77, 8'd1, 8'd2)) begin
      n_bad++; $display("FAIL srst_k1_out: got vld %b ofm %h want 1 %h", bus.POLGLB_OfmVld, bus.POLGLB_Ofm, mkv(8'd77, 8'd1, 8'd2));
    end
    bus.GLBPOL_OfmRdy = 1'b1;
    tick();
    bus.GLBPOL_OfmRdy = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL srst_k1_done: got %b want 1", done); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; ccu_rst = 1'b0; ccu_start = 1'b0; ccu_k = '0; ccu_num = '0;
    bus.GLBPOL_MapVld = 1'b0; bus.GLBPOL_Map = '0; bus.MIFPOL_Rdy = 1'b0;
    bus.MIFPOL_Ofm = '0; bus.MIFPOL_OfmVld = 1'b0; bus.GLBPOL_OfmRdy = 1'b0;
    test_reset();
    test_basic();
    test_rdy_toggle();
    test_out_hold();
    test_k_zero();
    test_zero_points();
    test_soft_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
